// File: rtl/fixed_point_mac.sv
// Pipelined signed fixed-point multiply-accumulate unit.
// Computes sum(a_i*b_i) over a vector at full precision with guard bits.
// Rounding and saturation are applied once, when the last term arrives.
// A single global enable freezes every stage while a result is stalled downstream.
module fixed_point_mac #(
    parameter int FIXED_POINT_LENGTH   = 16,
    parameter int FIXED_POINT_POSITION = 10,  // must be >= 2
    parameter int ACC_GUARD_BITS       = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [FIXED_POINT_LENGTH-1:0] fixed_point_1_in,
    input  logic [FIXED_POINT_LENGTH-1:0] fixed_point_2_in,
    input  logic                          last_in,
    input  logic                          round_mode_in,
    output logic [FIXED_POINT_LENGTH-1:0] result_out,
    output logic                          result_valid_out,
    input  logic                          result_ready_in,
    output logic                          saturated_out
);

    localparam int L  = FIXED_POINT_LENGTH;
    localparam int P  = FIXED_POINT_POSITION;
    localparam int PW = 2 * L;                 // product width
    localparam int AW = PW + ACC_GUARD_BITS;   // accumulator width
    localparam int SW = AW + 1 - P;            // rounded and shifted width

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [L-1:0]  RES_MAX = {1'b0, {(L-1){1'b1}}};
    localparam logic signed [L-1:0]  RES_MIN = {1'b1, {(L-1){1'b0}}};
    localparam logic signed [AW:0]   HALF    = {{(AW+1-P){1'b0}}, 1'b1, {(P-1){1'b0}}};

    // Clamp a one-bit-wider accumulator sum back into the accumulator range.
    function automatic logic signed [AW-1:0] acc_sat(input logic signed [AW:0] s);
        if (s[AW] != s[AW-1]) return s[AW] ? ACC_MIN : ACC_MAX;
        return s[AW-1:0];
    endfunction

    function automatic logic acc_ovf(input logic signed [AW:0] s);
        return s[AW] ^ s[AW-1];
    endfunction

    // Optional half-LSB add, then arithmetic shift out the extra fraction bits.
    function automatic logic signed [SW-1:0] round_shift(input logic signed [AW-1:0] a,
                                                         input logic mode);
        logic signed [AW:0] t;
        t = {a[AW-1], a} + (mode ? HALF : '0);
        return t[AW:P];
    endfunction

    function automatic logic res_clamped(input logic signed [SW-1:0] v);
        return !((&v[SW-1:L-1]) || !(|v[SW-1:L-1]));
    endfunction

    function automatic logic signed [L-1:0] res_sat(input logic signed [SW-1:0] v);
        if (res_clamped(v)) return v[SW-1] ? RES_MIN : RES_MAX;
        return v[L-1:0];
    endfunction

    logic                 adv;
    logic                 vld_p1_q, last_p1_q, mode_p1_q;
    logic signed [L-1:0]  a_p1_q, b_p1_q;
    logic                 vld_p2_q, last_p2_q, mode_p2_q;
    logic signed [PW-1:0] prod_p2_q;
    logic                 vld_p3_q, last_p3_q, mode_p3_q, ovf_p3_q, first_q;
    logic signed [AW-1:0] acc_p3_q, acc_p3_d;
    logic signed [AW:0]   sum_p3;
    logic                 ovf_p3_d;
    logic                 vld_p4_q, ovf_p4_q;
    logic signed [SW-1:0] rnd_p4_q;
    logic signed [L-1:0]  result_q;
    logic                 res_vld_q, sat_q;

    assign adv              = !(res_vld_q && !result_ready_in);
    assign ready_out        = rst_n_in && adv;
    assign result_out       = result_q;
    assign result_valid_out = res_vld_q;
    assign saturated_out    = sat_q;

    // Accumulator next state: restart on the first beat of a vector, clamp instead of wrapping.
    always_comb begin
        sum_p3   = {(first_q ? ACC_MIN[AW-1] & 1'b0 : acc_p3_q[AW-1]), (first_q ? '0 : acc_p3_q)}
                 + {{(AW+1-PW){prod_p2_q[PW-1]}}, prod_p2_q};
        acc_p3_d = acc_sat(sum_p3);
        ovf_p3_d = (first_q ? 1'b0 : ovf_p3_q) | acc_ovf(sum_p3);
    end

    // Data path registers; contents are qualified by the valid bits so they need no reset.
    always_ff @(posedge clk_in) begin
        if (adv) begin
            // S1: capture operands
            a_p1_q    <= fixed_point_1_in;
            b_p1_q    <= fixed_point_2_in;
            last_p1_q <= last_in;
            mode_p1_q <= round_mode_in;
            // S2: full-width signed product
            prod_p2_q <= PW'(a_p1_q) * PW'(b_p1_q);
            last_p2_q <= last_p1_q;
            mode_p2_q <= mode_p1_q;
            // S3: sideband that follows the accumulator
            last_p3_q <= last_p2_q;
            mode_p3_q <= mode_p2_q;
            // S4: round and shift the finished sum
            rnd_p4_q  <= round_shift(acc_p3_q, mode_p3_q);
            ovf_p4_q  <= ovf_p3_q;
        end
    end

    // Control, accumulator and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            vld_p4_q  <= 1'b0;
            first_q   <= 1'b1;
            acc_p3_q  <= '0;
            ovf_p3_q  <= 1'b0;
            res_vld_q <= 1'b0;
            result_q  <= '0;
            sat_q     <= 1'b0;
        end else if (adv) begin
            vld_p1_q <= valid_in;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                acc_p3_q <= acc_p3_d;
                ovf_p3_q <= ovf_p3_d;
                first_q  <= last_p2_q;
            end
            vld_p4_q  <= vld_p3_q && last_p3_q;
            res_vld_q <= vld_p4_q;
            if (vld_p4_q) begin
                result_q <= res_sat(rnd_p4_q);
                sat_q    <= res_clamped(rnd_p4_q) | ovf_p4_q;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_mac.sv
// Self-checking bench for fixed_point_mac: directed table, multi-cycle corner
// sequences, and randomized vectors scored against an arithmetic reference model.
module tb_fixed_point_mac;

    localparam int L = 16;
    localparam int P = 10;
    localparam int G = 8;
    localparam longint AMAX = (longint'(1) <<< (2*L+G-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (2*L+G-1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in, ready_out, last_in, mode_in;
    logic [L-1:0]  a_in, b_in, result;
    logic          result_valid, result_ready, saturated;

    always #5 clk = ~clk;

    fixed_point_mac #(
        .FIXED_POINT_LENGTH(L),
        .FIXED_POINT_POSITION(P),
        .ACC_GUARD_BITS(G)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .fixed_point_1_in(a_in),
        .fixed_point_2_in(b_in),
        .last_in(last_in),
        .round_mode_in(mode_in),
        .result_out(result),
        .result_valid_out(result_valid),
        .result_ready_in(result_ready),
        .saturated_out(saturated)
    );

    typedef struct {
        logic [L-1:0] a;
        logic [L-1:0] b;
        logic         mode;
        logic [L-1:0] exp_r;
        logic         exp_s;
    } vec_t;

    typedef struct {
        logic [L-1:0] r;
        logic         s;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact dot product, clamped at the accumulator range, then rounded and saturated.
    function automatic exp_t finish_vec(input longint acc, input bit ovf, input bit mode);
        exp_t   e;
        longint q;
        q = (acc + (mode ? (longint'(1) <<< (P-1)) : 0)) >>> P;
        if (q > 32767) begin
            e.r = 16'h7FFF; e.s = 1'b1;
        end else if (q < -32768) begin
            e.r = 16'h8000; e.s = 1'b1;
        end else begin
            e.r = 16'(q); e.s = ovf;
        end
        return e;
    endfunction

    task automatic send_beat(input logic [L-1:0] a, input logic [L-1:0] b,
                             input logic last, input logic mode, output bit ok);
        int w;
        w = 0;
        @(negedge clk);
        valid_in = 1'b1; a_in = a; b_in = b; last_in = last; mode_in = mode;
        #1;
        while (!ready_out && w < 500) begin
            @(negedge clk); #1; w++;
        end
        ok = ready_out;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_beat: ready_out stayed 0 for %0d cycles", w);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Waits (bounded) for a result, captures it and lets it be consumed (result_ready must be 1).
    task automatic get_result(output logic [L-1:0] r, output logic s, output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!result_valid) begin
            n_chk++; n_fail++;
            $display("FAIL get_result: no result_valid within %0d cycles", cyc);
            r = '0; s = 1'b0;
        end else begin
            r = result; s = saturated;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t         tbl[8];
        logic [L-1:0] r;
        logic         s;
        int           cyc;
        bit           ok;
        bit           drv_done;

        tbl[0] = '{16'h0400, 16'h0600, 1'b0, 16'h0600, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1};
        tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h7FFF, 1'b1};
        tbl[3] = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000, 1'b1};
        tbl[4] = '{16'hFFFF, 16'h0200, 1'b0, 16'hFFFF, 1'b0};
        tbl[5] = '{16'h0001, 16'h0200, 1'b1, 16'h0001, 1'b0};
        tbl[6] = '{16'h0001, 16'h0200, 1'b0, 16'h0000, 1'b0};
        tbl[7] = '{16'hFFFF, 16'h0200, 1'b1, 16'h0000, 1'b0};

        rst_n = 1'b0; valid_in = 1'b0; a_in = '0; b_in = '0;
        last_in = 1'b0; mode_in = 1'b0; result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset result_out", 32'(result), 0);
        check("reset result_valid_out", 32'(result_valid), 0);
        check("reset saturated_out", 32'(saturated), 0);
        check("reset ready_out", 32'(ready_out), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            send_beat(tbl[i].a, tbl[i].b, 1'b1, tbl[i].mode, ok);
            get_result(r, s, cyc);
            check($sformatf("table[%0d] result", i), 32'(r), 32'(tbl[i].exp_r));
            check($sformatf("table[%0d] saturated", i), 32'(s), 32'(tbl[i].exp_s));
            if (i == 0) check("latency cycles", 32'(cyc), 4);
        end

        // Guard bits: 961.0 - 961.0 + 1.0 must not clamp in the accumulator.
        send_beat(16'h7C00, 16'h7C00, 1'b0, 1'b0, ok);
        send_beat(16'h8400, 16'h7C00, 1'b0, 1'b0, ok);
        send_beat(16'h0400, 16'h0400, 1'b1, 1'b0, ok);
        get_result(r, s, cyc);
        check("guard result", 32'(r), 32'h0400);
        check("guard saturated", 32'(s), 0);

        // Backpressure: three results queued behind a stalled output.
        result_ready = 1'b0;
        send_beat(16'h0400, 16'h0400, 1'b1, 1'b0, ok);
        send_beat(16'h0800, 16'h0400, 1'b1, 1'b0, ok);
        send_beat(16'h0C00, 16'h0400, 1'b1, 1'b0, ok);
        repeat (6) @(posedge clk);
        #1;
        check("stall ready_out", 32'(ready_out), 0);
        check("stall result_valid", 32'(result_valid), 1);
        check("stall result held", 32'(result), 32'h0400);
        result_ready = 1'b1;
        get_result(r, s, cyc);
        check("release result 0", 32'(r), 32'h0400);
        get_result(r, s, cyc);
        check("release result 1", 32'(r), 32'h0800);
        get_result(r, s, cyc);
        check("release result 2", 32'(r), 32'h0C00);

        // Reset in the middle of a vector discards partial sum and in-flight beats.
        send_beat(16'h0400, 16'h0400, 1'b0, 1'b0, ok);
        send_beat(16'h0400, 16'h0400, 1'b0, 1'b0, ok);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset result_out", 32'(result), 0);
        check("midreset result_valid", 32'(result_valid), 0);
        check("midreset saturated", 32'(saturated), 0);
        check("midreset ready_out", 32'(ready_out), 0);
        rst_n = 1'b1;
        send_beat(16'h0400, 16'h0400, 1'b1, 1'b0, ok);
        get_result(r, s, cyc);
        check("post-reset result", 32'(r), 32'h0400);
        check("post-reset saturated", 32'(s), 0);
        repeat (8) @(posedge clk);
        #1;
        check("no stray result", 32'(result_valid), 0);

        // Random vectors with random backpressure.
        drv_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 1000; v++) begin
                    int     len;
                    bit     mode;
                    longint acc;
                    bit     ovf;
                    len  = $urandom_range(1, 16);
                    mode = 1'($urandom_range(0, 1));
                    acc  = 0;
                    ovf  = 1'b0;
                    for (int k = 0; k < len; k++) begin
                        logic [31:0]  ra, rb;
                        logic [L-1:0] a, b;
                        ra = $urandom; rb = $urandom;
                        a = ra[31] ? ra[15:0] : {{4{ra[11]}}, ra[11:0]};
                        b = rb[31] ? rb[15:0] : {{4{rb[11]}}, rb[11:0]};
                        if ($urandom_range(0, 7) == 0) @(negedge clk);
                        send_beat(a, b, (k == len - 1), mode, ok);
                        acc = acc + longint'($signed(a)) * longint'($signed(b));
                        if (acc > AMAX) begin acc = AMAX; ovf = 1'b1; end
                        if (acc < AMIN) begin acc = AMIN; ovf = 1'b1; end
                    end
                    exp_q.push_back(finish_vec(acc, ovf, mode));
                end
                drv_done = 1'b1;
            end
            begin
                int got;
                int cycles;
                exp_t e;
                got = 0;
                cycles = 0;
                while (got < 1000 && cycles < 80000) begin
                    @(negedge clk);
                    result_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    cycles++;
                    if (result_valid && result_ready) begin
                        if (exp_q.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL random: unexpected result 0x%0h", result);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("random[%0d] {sat,result}", got),
                                  {15'd0, saturated, result}, {15'd0, e.s, e.r});
                        end
                        got++;
                    end
                end
                if (got < 1000) begin
                    n_chk++; n_fail++;
                    $display("FAIL random: only %0d of 1000 results in %0d cycles", got, cycles);
                end
                result_ready = 1'b1;
            end
        join
        check("random driver finished", 32'(drv_done), 1);
        check("random queue drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
